// File: rtl/alu_pkg.sv
// Shared types and result-field offsets for the handshaked ALU core.
package alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_CMP = 3'b101,
      OP_MUL = 3'b110,
      OP_DIV = 3'b111
   } alu_op_t;

   typedef enum logic [2:0] {
      IDLE,
      CALC,
      MULW,
      DIV,
      HOLD
   } alu_state_t;

   // Compare result packing within result[2:0]
   localparam int unsigned CMP_LT_BIT = 0;
   localparam int unsigned CMP_EQ_BIT = 1;
   localparam int unsigned CMP_GT_BIT = 2;

endpackage

// File: rtl/alu_div_iter.sv
// Restoring divider: one quotient bit per cycle, MSB first, WIDTH cycles from start to done.
module alu_div_iter #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             arst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;

   logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
   logic [WIDTH-1:0] rem_src, quo_src, dvs_src;
   logic [WIDTH-1:0] rem_nxt, quo_nxt;
   logic [WIDTH:0]   trial, diff;
   logic [CW-1:0]    cnt;
   logic             busy;

   // The start cycle already performs the first iteration on the fresh operands
   always_comb begin
      rem_src = start ? '0       : rem_q;
      quo_src = start ? dividend : quo_q;
      dvs_src = start ? divisor  : dvs_q;
      trial   = {rem_src, quo_src[WIDTH-1]};
      diff    = trial - {1'b0, dvs_src};
      if (trial >= {1'b0, dvs_src}) begin
         rem_nxt = diff[WIDTH-1:0];
         quo_nxt = {quo_src[WIDTH-2:0], 1'b1};
      end else begin
         rem_nxt = trial[WIDTH-1:0];
         quo_nxt = {quo_src[WIDTH-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         rem_q <= '0;
         quo_q <= '0;
         dvs_q <= '0;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            dvs_q <= divisor;
            cnt   <= CW'(1);
            busy  <= 1'b1;
         end else if (busy) begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            cnt   <= cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

   assign quotient  = quo_q;
   assign remainder = rem_q;

endmodule

// File: rtl/alu_hs_core.sv
// Handshaked ALU: captures one request, computes (iteratively for divide), holds the result until accepted.
module alu_hs_core
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH    = 4,
   parameter int unsigned MUL_PIPE = 0
) (
   input  logic               clk,
   input  logic               arst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [2:0]         op,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] result,
   output logic               carry_out,
   output logic               sign,
   output logic               a_greater,
   output logic               a_equal,
   output logic               a_less,
   output logic               div_by_zero
);

   alu_state_t state, state_nxt;

   logic [WIDTH-1:0]   a_q, b_q;
   alu_op_t            op_q;
   logic               in_xfer, load;
   logic               div_start, div_done;
   logic [WIDTH-1:0]   div_quo, div_rem;
   logic [WIDTH:0]     sum;
   logic [2*WIDTH-1:0] calc_res, res_q;
   logic               calc_carry, calc_sign, calc_gt, calc_eq, calc_lt, calc_dz;
   logic               carry_q, sign_q, gt_q, eq_q, lt_q, dz_q;

   assign in_xfer   = in_valid & in_ready;
   assign div_start = (state == CALC) && (op_q == OP_DIV) && (b_q != '0);
   // Result registers load only on HOLD entry, so they read zero whenever out_valid is low
   assign load      = (state_nxt == HOLD) && (state != HOLD);

   alu_div_iter #(
      .WIDTH (WIDTH)
   ) u_div (
      .clk       (clk),
      .arst      (arst),
      .start     (div_start),
      .dividend  (a_q),
      .divisor   (b_q),
      .done      (div_done),
      .quotient  (div_quo),
      .remainder (div_rem)
   );

   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (in_valid) state_nxt = CALC;
         CALC: begin
            if (op_q == OP_MUL && MUL_PIPE != 0)    state_nxt = MULW;
            else if (op_q == OP_DIV && b_q != '0)  state_nxt = DIV;
            else                                   state_nxt = HOLD;
         end
         MULW: state_nxt = HOLD;
         DIV:  if (div_done) state_nxt = HOLD;
         HOLD: if (out_ready) state_nxt = in_valid ? CALC : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready    = (state == IDLE) || ((state == HOLD) && out_ready);
      out_valid   = (state == HOLD);
      result      = res_q;
      carry_out   = carry_q;
      sign        = sign_q;
      a_greater   = gt_q;
      a_equal     = eq_q;
      a_less      = lt_q;
      div_by_zero = dz_q;
   end

   always_comb begin
      sum        = {1'b0, a_q} + {1'b0, b_q};
      calc_res   = '0;
      calc_carry = 1'b0;
      calc_sign  = 1'b0;
      calc_dz    = 1'b0;
      calc_gt    = a_q > b_q;
      calc_eq    = a_q == b_q;
      calc_lt    = a_q < b_q;
      unique case (op_q)
         OP_ADD: begin
            calc_res[WIDTH:0] = sum;
            calc_carry        = sum[WIDTH];
         end
         OP_SUB: begin
            calc_res[WIDTH-1:0] = calc_lt ? (b_q - a_q) : (a_q - b_q);
            calc_sign           = calc_lt;
         end
         OP_AND: calc_res[WIDTH-1:0] = a_q & b_q;
         OP_OR:  calc_res[WIDTH-1:0] = a_q | b_q;
         OP_XOR: calc_res[WIDTH-1:0] = a_q ^ b_q;
         OP_CMP: begin
            calc_res[CMP_GT_BIT] = calc_gt;
            calc_res[CMP_EQ_BIT] = calc_eq;
            calc_res[CMP_LT_BIT] = calc_lt;
         end
         OP_MUL: calc_res = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
         OP_DIV: begin
            if (b_q == '0) begin
               calc_res = {a_q, {WIDTH{1'b1}}};
               calc_dz  = 1'b1;
            end else begin
               calc_res = {div_rem, div_quo};
            end
         end
         default: calc_res = '0;
      endcase
   end

   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= OP_ADD;
         res_q   <= '0;
         carry_q <= 1'b0;
         sign_q  <= 1'b0;
         gt_q    <= 1'b0;
         eq_q    <= 1'b0;
         lt_q    <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         if (in_xfer) begin
            a_q  <= a;
            b_q  <= b;
            op_q <= alu_op_t'(op);
         end
         if (load) begin
            res_q   <= calc_res;
            carry_q <= calc_carry;
            sign_q  <= calc_sign;
            gt_q    <= calc_gt;
            eq_q    <= calc_eq;
            lt_q    <= calc_lt;
            dz_q    <= calc_dz;
         end else if (state == HOLD && out_ready) begin
            res_q   <= '0;
            carry_q <= 1'b0;
            sign_q  <= 1'b0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
            dz_q    <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_hs_core.sv
// Randomized and directed bench for alu_hs_core (WIDTH=4) against an arithmetic reference model.
module tb_alu_hs_core;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         arst = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic         sel = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic [2:0]   op = '0;

   logic         ird0, ov0, cy0, sg0, gt0, eq0, lt0, dz0;
   logic         ird1, ov1, cy1, sg1, gt1, eq1, lt1, dz1;
   logic [2*W-1:0] res0, res1;

   logic           o_ready, o_valid;
   logic [2*W-1:0] o_result;
   logic [13:0]    obs;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   alu_hs_core #(.WIDTH(W), .MUL_PIPE(0)) dut0 (
      .clk(clk), .arst(arst), .in_valid(in_valid & ~sel), .in_ready(ird0),
      .a(a), .b(b), .op(op), .out_valid(ov0), .out_ready(out_ready & ~sel),
      .result(res0), .carry_out(cy0), .sign(sg0), .a_greater(gt0),
      .a_equal(eq0), .a_less(lt0), .div_by_zero(dz0)
   );

   alu_hs_core #(.WIDTH(W), .MUL_PIPE(1)) dut1 (
      .clk(clk), .arst(arst), .in_valid(in_valid & sel), .in_ready(ird1),
      .a(a), .b(b), .op(op), .out_valid(ov1), .out_ready(out_ready & sel),
      .result(res1), .carry_out(cy1), .sign(sg1), .a_greater(gt1),
      .a_equal(eq1), .a_less(lt1), .div_by_zero(dz1)
   );

   assign o_ready  = sel ? ird1 : ird0;
   assign o_valid  = sel ? ov1  : ov0;
   assign o_result = sel ? res1 : res0;
   assign obs = sel ? {res1, cy1, sg1, gt1, eq1, lt1, dz1}
                    : {res0, cy0, sg0, gt0, eq0, lt0, dz0};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // {result, carry, sign, gt, eq, lt, dz} straight from the arithmetic definitions
   function automatic logic [13:0] model(input int unsigned x, input int unsigned y, input int unsigned o);
      int unsigned r;
      logic c, s, z;
      r = 0; c = 1'b0; s = 1'b0; z = 1'b0;
      case (o)
         0: begin r = x + y; c = (x + y) >= (1 << W); end
         1: begin r = (x >= y) ? x - y : y - x; s = y > x; end
         2: r = x & y;
         3: r = x | y;
         4: r = x ^ y;
         5: r = ((x > y) ? 4 : 0) + ((x == y) ? 2 : 0) + ((x < y) ? 1 : 0);
         6: r = x * y;
         default: begin
            if (y == 0) begin r = x * (1 << W) + (1 << W) - 1; z = 1'b1; end
            else        r = (x % y) * (1 << W) + x / y;
         end
      endcase
      return {r[7:0], c, s, x > y, x == y, x < y, z};
   endfunction

   function automatic int exp_lat(input int unsigned y, input int unsigned o);
      if (o == 6)           return sel ? 3 : 2;
      if (o == 7 && y != 0) return W + 2;
      return 2;
   endfunction

   // Called at (or just after) a negedge; returns at the negedge following the input transfer edge
   task automatic send(input int unsigned x, input int unsigned y, input int unsigned o);
      int n;
      n = 0;
      a = x[W-1:0]; b = y[W-1:0]; op = o[2:0]; in_valid = 1'b1;
      #1;
      while (!o_ready && n < 50) begin
         @(negedge clk); #1; n++;
      end
      if (!o_ready) check("send_timeout", 32'd0, 32'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b0;
   endtask

   // Leaves out_ready high so the next edge completes the output transfer
   task automatic recv(input logic [13:0] exp, input int lat, input int stall, input string tag);
      int k;
      logic bad;
      logic [13:0] snap;
      k = 0; bad = 1'b0;
      #1;
      while (!o_valid && k < 40) begin
         if (o_ready) bad = 1'b1;
         @(negedge clk); #1; k++;
      end
      check({tag, "_lat"}, k + 1, lat);
      check({tag, "_busy_rdy"}, bad, 1'b0);
      check({tag, "_out"}, obs, exp);
      snap = obs; bad = 1'b0;
      for (int i = 0; i < stall; i++) begin
         @(negedge clk); #1;
         if (obs !== snap || !o_valid || o_ready) bad = 1'b1;
      end
      if (stall > 0) check({tag, "_hold"}, bad, 1'b0);
      out_ready = 1'b1;
   endtask

   task automatic do_op(input int unsigned x, input int unsigned y, input int unsigned o,
                        input int stall, input string tag);
      send(x, y, o);
      recv(model(x, y, o), exp_lat(y, o), stall, tag);
   endtask

   task automatic go_idle(input string tag);
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      #1;
      check({tag, "_idle_valid"}, o_valid, 1'b0);
      check({tag, "_idle_res"}, o_result, '0);
   endtask

   initial begin
      logic bad;
      int unsigned x, y, o;

      @(negedge clk); #1;
      check("rst_ready", o_ready, 1'b1);
      check("rst_valid", o_valid, 1'b0);
      check("rst_out", obs, '0);
      @(negedge clk);
      arst = 1'b1;

      do_op(12, 7, 0, 0, "add_12_7");
      do_op(9, 5, 0, 0, "add_9_5");
      do_op(3, 9, 1, 0, "sub_3_9");
      do_op(15, 15, 6, 0, "mul0_15_15");
      do_op(13, 4, 7, 0, "div_13_4");
      do_op(7, 0, 7, 3, "div_7_0");
      #1;
      check("b2b_ready", o_ready, 1'b1);
      do_op(2, 5, 0, 0, "b2b_add");
      go_idle("dir0");

      sel = 1'b1;
      do_op(15, 15, 6, 0, "mul1_15_15");
      do_op(6, 3, 0, 1, "mul1_add");
      do_op(5, 3, 6, 0, "mul1_5_3");
      go_idle("dir1");
      sel = 1'b0;

      send(13, 4, 7);
      @(negedge clk);
      @(negedge clk);
      arst = 1'b0;
      #1;
      check("midrst_valid", o_valid, 1'b0);
      check("midrst_ready", o_ready, 1'b1);
      check("midrst_out", obs, '0);
      @(negedge clk);
      arst = 1'b1;
      bad = 1'b0;
      repeat (8) begin
         @(negedge clk); #1;
         if (o_valid) bad = 1'b1;
      end
      check("midrst_no_valid", bad, 1'b0);
      do_op(1, 1, 0, 0, "post_rst_add");
      go_idle("rst");

      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         for (int i = 0; i < 40; i++) begin
            x = $urandom_range(0, (1 << W) - 1);
            y = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, (1 << W) - 1);
            o = $urandom_range(0, 7);
            do_op(x, y, o, $urandom_range(0, 2), "rand");
         end
         go_idle("rand");
      end
      sel = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
